// File: rtl/shift_arbiter_pkg.sv
// Shared types for the shift arbiter: shift modes, arbiter FSM states, shift-amount width.
package shift_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    MODE_LSL = 3'b000,
    MODE_LSR = 3'b001,
    MODE_ASL = 3'b010,
    MODE_ASR = 3'b011,
    MODE_ROL = 3'b100,
    MODE_ROR = 3'b101
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Codes 110 and 111 have no shifter operation behind them
  function automatic logic mode_illegal(input logic [2:0] mode);
    return mode[2] & mode[1];
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request, response and shifter-facing signals of the shift arbiter.
// The arbiter uses the slave modport; the requester/shifter side uses master.
interface shift_arbiter_if
  import shift_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REQ   = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*REG_WIDTH-1:0] req_op_a;
  logic [NUM_REQ*SHAMT_W-1:0]   req_nbits;
  logic [NUM_REQ*3-1:0]         req_mode;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDX_W-1:0]     resp_id;
  logic [REG_WIDTH-1:0] resp_result;
  logic                 resp_error;

  logic [REG_WIDTH-1:0] sh_op_a;
  logic [SHAMT_W-1:0]   sh_nbits;
  logic [2:0]           sh_mode;
  logic                 sh_start;
  logic [REG_WIDTH-1:0] sh_result;
  logic                 sh_done;

  modport slave (
    input  req_valid, req_op_a, req_nbits, req_mode, resp_ready, sh_result, sh_done,
    output req_ready, resp_valid, resp_id, resp_result, resp_error,
           sh_op_a, sh_nbits, sh_mode, sh_start
  );

  modport master (
    output req_valid, req_op_a, req_nbits, req_mode, resp_ready, sh_result, sh_done,
    input  req_ready, resp_valid, resp_id, resp_result, resp_error,
           sh_op_a, sh_nbits, sh_mode, sh_start
  );

endinterface

// File: rtl/shift_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping at N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IDX_W = $clog2(N);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one barrel shifter among NUM_REQ requesters with timeout.
// Optional SHIFT_ARB_ZERO_BYPASS_EN: legal nbits==0 commands answer directly with op_a.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic clock,
  input  logic reset,
  shift_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [REG_WIDTH-1:0] opA_q, opA_d;
  logic [SHAMT_W-1:0]   nbits_q, nbits_d;
  logic [2:0]           mode_q, mode_d;
  logic [REG_WIDTH-1:0] result_q, result_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   rrGnt;
  logic [IDX_W-1:0]     rrIdx;
  logic [REG_WIDTH-1:0] selOpA;
  logic [SHAMT_W-1:0]   selNbits;
  logic [2:0]           selMode;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (rrGnt),
    .idx_o (rrIdx)
  );

  assign selOpA   = bus.req_op_a[rrIdx*REG_WIDTH +: REG_WIDTH];
  assign selNbits = bus.req_nbits[rrIdx*SHAMT_W +: SHAMT_W];
  assign selMode  = bus.req_mode[rrIdx*3 +: 3];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      opA_q    <= '0;
      nbits_q  <= '0;
      mode_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      opA_q    <= opA_d;
      nbits_q  <= nbits_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    opA_d    = opA_q;
    nbits_d  = nbits_q;
    mode_d   = mode_q;
    result_d = result_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = rrIdx;
          opA_d   = selOpA;
          nbits_d = selNbits;
          mode_d  = selMode;
          if (mode_illegal(selMode)) begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = ISSUE;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
            if (selNbits == '0) begin
              result_d = selOpA;
              error_d  = 1'b0;
              state_d  = RESP;
            end
`endif
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      // A done arriving on the last counted cycle still beats the timeout
      WAIT: begin
        if (bus.sh_done) begin
          result_d = bus.sh_result;
          error_d  = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from state so everything reads zero outside its phase
  always_comb begin
    bus.req_ready   = (state_q == IDLE && !reset) ? rrGnt : '0;
    bus.resp_valid  = (state_q == RESP);
    bus.resp_id     = (state_q == RESP) ? grant_q : '0;
    bus.resp_result = (state_q == RESP) ? result_q : '0;
    bus.resp_error  = (state_q == RESP) ? error_q : 1'b0;
    bus.sh_start    = (state_q == ISSUE);
    bus.sh_op_a     = '0;
    bus.sh_nbits    = '0;
    bus.sh_mode     = '0;
    if (state_q == ISSUE || state_q == WAIT) begin
      bus.sh_op_a  = opA_q;
      bus.sh_nbits = nbits_q;
      bus.sh_mode  = mode_q;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural one-cycle barrel shifter model.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  shift_arbiter_if #(.REG_WIDTH(W), .NUM_REQ(N)) bus ();

  shift_arbiter #(.REG_WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int startCount = 0;
  logic modelEn = 1'b1;
  logic modelDone = 1'b0;
  logic strayDone = 1'b0;
  logic [W-1:0] modelResult = '0;

  assign bus.sh_done   = modelDone | strayDone;
  assign bus.sh_result = modelResult;

  function automatic logic [W-1:0] shiftRef(logic [W-1:0] op, logic [4:0] nb, logic [2:0] md);
    case (md)
      MODE_LSL, MODE_ASL: return op << nb;
      MODE_LSR:           return op >> nb;
      MODE_ASR:           return W'($signed(op) >>> nb);
      MODE_ROL:           return (op << nb) | (op >> (W - int'(nb)));
      MODE_ROR:           return (op >> nb) | (op << (W - int'(nb)));
      default:            return '0;
    endcase
  endfunction

  // Shifter stand-in: answers with done the cycle after it sees start
  always @(posedge clock) begin
    modelDone <= 1'b0;
    if (bus.sh_start) begin
      startCount <= startCount + 1;
      if (modelEn) begin
        modelDone   <= 1'b1;
        modelResult <= shiftRef(bus.sh_op_a, bus.sh_nbits, bus.sh_mode);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s failed: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [W-1:0] op,
                               input logic [4:0] nb, input logic [2:0] md);
    bus.req_valid[i]         = v;
    bus.req_op_a[i*W +: W]   = op;
    bus.req_nbits[i*5 +: 5]  = nb;
    bus.req_mode[i*3 +: 3]   = md;
  endtask

  task automatic waitGrant(input string tag, output int idx);
    idx = -1;
    for (int n = 0; n < 40; n++) begin
      if (bus.req_ready != '0) begin
        for (int b = 0; b < N; b++) if (bus.req_ready[b]) idx = b;
        break;
      end
      tick();
    end
    checkOutput({tag, "_onehot"}, 64'($onehot(bus.req_ready)), 64'd1);
  endtask

  initial begin
    int g;
    int s0;
    int n;
    int rrOrder [6] = '{0, 1, 2, 3, 0, 1};

    bus.req_valid  = '0;
    bus.req_op_a   = '0;
    bus.req_nbits  = '0;
    bus.req_mode   = '0;
    bus.resp_ready = 1'b1;

    tick();
    tick();
    checkOutput("reset_ctrl", 64'({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_error,
                                   bus.sh_start, bus.sh_nbits, bus.sh_mode}), 64'd0);
    checkOutput("reset_data", 64'({bus.resp_result, bus.sh_op_a}), 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] single request");
    applyStimulus(0, 1'b1, 32'h0000_00F0, 5'd4, 3'b000);
    settle();
    checkOutput("t1_ready", 64'(bus.req_ready), 64'h1);
    tick();
    applyStimulus(0, 1'b0, '0, '0, '0);
    settle();
    checkOutput("t1_start", 64'(bus.sh_start), 64'd1);
    checkOutput("t1_sh_bus", 64'({bus.sh_op_a, bus.sh_nbits, bus.sh_mode}),
                64'({32'h0000_00F0, 5'd4, 3'b000}));
    tick();
    checkOutput("t1_wait_novalid", 64'(bus.resp_valid), 64'd0);
    tick();
    checkOutput("t1_resp", 64'({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_result}),
                64'({1'b1, 2'd0, 1'b0, 32'h0000_0F00}));
    tick();
    checkOutput("t1_resp_drop", 64'(bus.resp_valid), 64'd0);

    $display("[TB] round robin");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, W'(i + 1), 5'd1, 3'b000);
    settle();
    for (int k = 0; k < 6; k++) begin
      waitGrant("rr", g);
      checkOutput($sformatf("rr_grant%0d", k), 64'(g), 64'(rrOrder[k]));
      tick();
    end
    bus.req_valid = 4'b1001;
    settle();
    waitGrant("rr_ptr2", g);
    checkOutput("rr_ptr2_grant", 64'(g), 64'd3);
    tick();
    waitGrant("rr_wrap", g);
    checkOutput("rr_wrap_grant", 64'(g), 64'd0);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();

    $display("[TB] illegal mode");
    s0 = startCount;
    applyStimulus(1, 1'b1, 32'hFFFF_FFFF, 5'd3, 3'b111);
    settle();
    waitGrant("ill", g);
    checkOutput("ill_grant", 64'(g), 64'd1);
    tick();
    applyStimulus(1, 1'b0, '0, '0, '0);
    settle();
    checkOutput("ill_resp", 64'({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_result}),
                64'({1'b1, 2'd1, 1'b1, 32'h0}));
    tick();
    tick();
    checkOutput("ill_no_start", 64'(startCount - s0), 64'd0);

    $display("[TB] timeout");
    modelEn = 1'b0;
    applyStimulus(2, 1'b1, 32'h5, 5'd1, 3'b000);
    settle();
    waitGrant("to", g);
    checkOutput("to_grant", 64'(g), 64'd2);
    tick();
    applyStimulus(2, 1'b0, '0, '0, '0);
    settle();
    checkOutput("to_start", 64'(bus.sh_start), 64'd1);
    n = 0;
    while (!bus.resp_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("to_wait_cycles", 64'(n - 1), 64'(TO));
    checkOutput("to_resp", 64'({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_result}),
                64'({1'b1, 2'd2, 1'b1, 32'h0}));
    tick();
    strayDone = 1'b1;
    tick();
    strayDone = 1'b0;
    settle();
    checkOutput("to_stray_ignored", 64'({bus.resp_valid, bus.sh_start}), 64'd0);
    tick();
    checkOutput("to_stray_later", 64'(bus.resp_valid), 64'd0);
    modelEn = 1'b1;

    $display("[TB] backpressure");
    bus.resp_ready = 1'b0;
    applyStimulus(3, 1'b1, 32'h8000_0001, 5'd1, 3'b011);
    applyStimulus(0, 1'b1, 32'h0000_0011, 5'd2, 3'b000);
    settle();
    waitGrant("bp", g);
    checkOutput("bp_grant", 64'(g), 64'd3);
    tick();
    applyStimulus(3, 1'b0, '0, '0, '0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_hold%0d", k),
                  64'({bus.resp_valid, bus.resp_error, bus.resp_result, bus.req_ready}),
                  64'({1'b1, 1'b0, 32'hC000_0000, 4'b0000}));
      if (k < 4) tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    checkOutput("bp_next_grant", 64'(bus.req_ready), 64'h1);

    $display("[TB] reset during wait");
    modelEn = 1'b0;
    tick();
    applyStimulus(0, 1'b0, '0, '0, '0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_ctrl", 64'({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_error,
                                 bus.sh_start, bus.sh_nbits, bus.sh_mode}), 64'd0);
    checkOutput("rst_data", 64'({bus.resp_result, bus.sh_op_a}), 64'd0);
    reset = 1'b0;
    strayDone = 1'b1;
    tick();
    strayDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_no_resp%0d", k), 64'(bus.resp_valid), 64'd0);
      tick();
    end
    modelEn = 1'b1;

    $display("[TB] zero shift");
    s0 = startCount;
    applyStimulus(2, 1'b1, 32'h1234_5678, 5'd0, 3'b000);
    settle();
    waitGrant("zb", g);
    checkOutput("zb_grant", 64'(g), 64'd2);
    tick();
    applyStimulus(2, 1'b0, '0, '0, '0);
    settle();
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
    checkOutput("zb_resp", 64'({bus.resp_valid, bus.resp_error, bus.resp_result}),
                64'({1'b1, 1'b0, 32'h1234_5678}));
    tick();
    checkOutput("zb_start_count", 64'(startCount - s0), 64'd0);
`else
    checkOutput("zb_start", 64'(bus.sh_start), 64'd1);
    tick();
    tick();
    checkOutput("zb_resp", 64'({bus.resp_valid, bus.resp_error, bus.resp_result}),
                64'({1'b1, 1'b0, 32'h1234_5678}));
    tick();
    checkOutput("zb_start_count", 64'(startCount - s0), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
